// File: rtl/pwm_ramp_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_controller_if
// Purpose  : Signal bundle between the motor-control front end and the PWM
//            ramp sequencer. Carries the target/direction request inputs and
//            the duty/direction/busy results handed on to the PWM and bridge.
// Ports    : sw        target duty magnitude (0 = stop)
//            dir_req   requested motor direction (level)
//            en        run enable
//            period_e  PWM period-start flag from the timer (clk-synchronous)
//            duty      duty value for the PWM CCR
//            dir       direction applied to the H-bridge
//            busy      sequencer is moving duty or waiting out dead-time
// Modports : master drives the requests and observes the results;
//            slave is the sequencer side.
// Revision : 1.0  initial release
// ============================================================================
interface pwm_ramp_controller_if #(
  parameter int DUTY_W = 7
);
  logic [DUTY_W-1:0] sw;
  logic              dir_req;
  logic              en;
  logic              period_e;
  logic [DUTY_W-1:0] duty;
  logic              dir;
  logic              busy;

  modport master (
    output sw, dir_req, en, period_e,
    input  duty, dir, busy
  );

  modport slave (
    input  sw, dir_req, en, period_e,
    output duty, dir, busy
  );
endinterface
`default_nettype wire

// File: rtl/pwm_ramp_controller.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_controller
// Purpose  : Soft-start / soft-stop and direction sequencer in front of the
//            PWM duty register. The applied duty slews toward the target by at
//            most STEP per ramp tick; a direction reversal first brakes the
//            duty to zero, then holds zero for DEAD_PER PWM periods before the
//            new direction reaches the H-bridge.
// Ports    : clk    system clock, all logic on its rising edge
//            rst_n  asynchronous active-low reset
//            bus    pwm_ramp_controller_if.slave
//                     in : sw, dir_req, en, period_e
//                     out: duty, dir, busy
// Params   : DUTY_W    width of duty/target values
//            STEP      largest duty change per ramp tick (1..2^DUTY_W-1)
//            RAMP_DIV  PWM periods per ramp tick (1..15)
//            DEAD_PER  PWM periods of zero duty before DIR flips (1..15)
// Revision : 1.0  initial release
// ============================================================================
module pwm_ramp_controller #(
  parameter int DUTY_W   = 7,
  parameter int STEP     = 4,
  parameter int RAMP_DIV = 1,
  parameter int DEAD_PER = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_ramp_controller_if.slave bus
);

  localparam int                CNT_W     = 4;
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_PER - 1);
  localparam logic [DUTY_W-1:0] STEP_W    = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = {DUTY_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q,  duty_d;
  logic              dir_q,   dir_d;
  logic              pe_q,    pe_d;
  logic [CNT_W-1:0]  div_q,   div_d;
  logic [CNT_W-1:0]  dead_q,  dead_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              per_tick;
  logic              ramp_tick;
  logic [DUTY_W-1:0] tgt;
  logic              dir_mismatch;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] up_sat;
  logic [DUTY_W-1:0] up_val;
  logic [DUTY_W-1:0] dn_sat;
  logic [DUTY_W-1:0] dn_val;
  logic [DUTY_W-1:0] ramp_val;
  logic [DUTY_W-1:0] brake_val;

  // --------------------------------------------------------------------------
  // Period edge detect and ramp divider.
  // A level held high on period_e yields a single per_tick; the divider is
  // free-running over per_ticks so the ramp cadence does not depend on the
  // current state.
  // --------------------------------------------------------------------------
  always_comb begin
    pe_d      = bus.period_e;
    per_tick  = bus.period_e & ~pe_q;
    div_d     = div_q;
    ramp_tick = 1'b0;
    if (per_tick) begin
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        ramp_tick = 1'b1;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Duty datapath.
  // The upward step is formed one bit wider so that a carry out saturates at
  // full scale instead of wrapping; both directions then clamp at the target
  // so the last step is exactly the remaining distance.
  // --------------------------------------------------------------------------
  always_comb begin
    tgt          = bus.en ? bus.sw : '0;
    dir_mismatch = (bus.dir_req != dir_q);

    up_sum = {1'b0, duty_q} + {1'b0, STEP_W};
    up_sat = up_sum[DUTY_W] ? DUTY_MAX : up_sum[DUTY_W-1:0];
    up_val = (up_sat > tgt) ? tgt : up_sat;

    dn_sat = (duty_q > STEP_W) ? (duty_q - STEP_W) : '0;
    dn_val = (dn_sat < tgt) ? tgt : dn_sat;

    if (tgt > duty_q) begin
      ramp_val = up_val;
    end else if (tgt < duty_q) begin
      ramp_val = dn_val;
    end else begin
      ramp_val = duty_q;
    end

    // Braking ignores the target: it always heads for zero.
    brake_val = dn_sat;
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state logic.
  // RAMP, HOLD and BRAKE share one ramp-tick update: a direction mismatch
  // (while enabled) takes priority and brakes, otherwise duty slews toward
  // the target. Arriving at the target decides HOLD versus IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;

    case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        if (ramp_tick && bus.en && (bus.sw != '0)) begin
          if (dir_mismatch) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end

      ST_RAMP, ST_HOLD, ST_BRAKE: begin
        if (ramp_tick) begin
          if (bus.en && dir_mismatch) begin
            duty_d = brake_val;
            if (brake_val == '0) begin
              state_d = ST_DEAD;
              dead_d  = '0;
            end else begin
              state_d = ST_BRAKE;
            end
          end else begin
            duty_d = ramp_val;
            if (ramp_val == tgt) begin
              state_d = (tgt == '0) ? ST_IDLE : ST_HOLD;
            end else begin
              state_d = ST_RAMP;
            end
          end
        end
      end

      ST_DEAD: begin
        // Dead-time counts raw PWM periods; the ramp divider is bypassed.
        duty_d = '0;
        if (per_tick) begin
          if (dead_q == DEAD_LAST) begin
            dead_d  = '0;
            dir_d   = bus.dir_req;
            state_d = (tgt == '0) ? ST_IDLE : ST_RAMP;
          end else begin
            dead_d = dead_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        duty_d  = '0;
        dead_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      pe_q    <= 1'b0;
      div_q   <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      pe_q    <= pe_d;
      div_q   <= div_d;
      dead_q  <= dead_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from flops so the CCR sees a glitch-free value.
  // --------------------------------------------------------------------------
  assign bus.duty = duty_q;
  assign bus.dir  = dir_q;
  assign bus.busy = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule
`default_nettype wire
